stitch_pipeline_egress_buffer: RTL and testbench

Receive-side companion to a stitched, fixed-latency, valid-only pipeline with no stall path. It admits work into the pipeline through credits and captures each pipeline output beat into a small FIFO. It presents that data downstream as a ready/valid stream. Because the pipeline cannot stall, the block guarantees no output beat is lost: it gates the upstream in_valid with credits equal to free FIFO slots minus beats already in flight.

---
 rtl/stitch_egress_pkg.sv | 21 ++
 rtl/stitch_egress_fifo.sv | 74 +++++++
 rtl/stitch_pipeline_egress_buffer.sv | 128 ++++++++++++
 tb/tb_stitch_pipeline_egress_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stitch_egress_pkg.sv
// Shared definitions for the stitched-pipeline egress buffer.
//   cnt_width : width of occupancy / in-flight counters for a given depth
//   ptr_width : width of FIFO read/write pointers for a given depth
//   ERR_*_BIT : bit positions of the sticky error flags in the packed
//               error vector held by the top level
package stitch_egress_pkg;

  localparam int unsigned ERR_OVERFLOW_BIT  = 0;
  localparam int unsigned ERR_UNDERFLOW_BIT = 1;
  localparam int unsigned ERR_PROTOCOL_BIT  = 2;
  localparam int unsigned ERR_W             = 3;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stitch_egress_fifo.sv
// Small synchronous FIFO used to capture pipeline output beats.
// The caller guarantees push is only asserted when there is room
// (not full, or a pop on the same edge) and pop only when not empty.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : write one word
//   pop             : retire the head word
//   rd_data         : head-of-FIFO word (storage at read pointer)
//   occupancy       : entries held
//   full, empty     : occupancy == DEPTH / occupancy == 0
module stitch_egress_fifo
  import stitch_egress_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned      PTR_W    = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  // Explicit wrap compare so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign rd_data   = mem[rd_ptr];
  assign occupancy = count;
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);

endmodule

// File: rtl/stitch_pipeline_egress_buffer.sv
// Receive-side companion to a fixed-latency, valid-only pipeline that
// cannot stall. Upstream issue is gated by credits (free FIFO slots minus
// beats already in flight) so every returning beat has a slot; returned
// beats are presented downstream as a ready/valid stream.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   issue_ready             : upstream may raise pipeline in_valid
//   issue_valid             : copy of pipeline in_valid
//   pipe_valid, pipe_data   : pipeline final-stage valid / data
//   out_valid, out_ready    : downstream handshake
//   out_data                : head-of-FIFO word
//   occupancy, inflight     : FIFO entries / beats issued not yet returned
//   err_overflow            : sticky, beat returned to a full FIFO with no pop
//   err_underflow           : sticky, beat returned with nothing in flight
//   err_protocol            : sticky, issue while issue_ready low
module stitch_pipeline_egress_buffer
  import stitch_egress_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PIPE_LATENCY = 3,
  parameter int unsigned CNT_W        = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  issue_ready,
  input  logic                  issue_valid,
  input  logic                  pipe_valid,
  input  logic [DATA_WIDTH-1:0] pipe_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy,
  output logic [CNT_W-1:0]      inflight,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic                  err_protocol
);

  localparam logic [CNT_W:0]   DEPTH_EXT    = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] INFLIGHT_MAX = '1;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [CNT_W:0]   committed;

  // Credits are DEPTH - occ - inflight; compare the sum against DEPTH in a
  // widened domain so protocol violations (sum > DEPTH) cannot wrap the
  // credit count back to nonzero.
  assign committed   = {1'b0, occ} + {1'b0, inflight_q};
  assign issue_ready = (committed < DEPTH_EXT);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = pipe_valid && (!full || pop);

  stitch_egress_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pipe_data),
    .pop       (pop),
    .rd_data   (out_data),
    .occupancy (occ),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    inflight_d = inflight_q;
    if (issue_valid && !pipe_valid) begin
      if (inflight_q != INFLIGHT_MAX) begin
        inflight_d = inflight_q + 1'b1;
      end
    end else if (pipe_valid && !issue_valid) begin
      if (inflight_q != '0) begin
        inflight_d = inflight_q - 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (pipe_valid && full && !pop) begin
      err_d[ERR_OVERFLOW_BIT] = 1'b1;
    end
    if (pipe_valid && (inflight_q == '0)) begin
      err_d[ERR_UNDERFLOW_BIT] = 1'b1;
    end
    if (issue_valid && !issue_ready) begin
      err_d[ERR_PROTOCOL_BIT] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      err_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign occupancy     = occ;
  assign inflight      = inflight_q;
  assign err_overflow  = err_q[ERR_OVERFLOW_BIT];
  assign err_underflow = err_q[ERR_UNDERFLOW_BIT];
  assign err_protocol  = err_q[ERR_PROTOCOL_BIT];

  // A legitimately returning beat was issued exactly PIPE_LATENCY edges ago.
  a_fixed_latency: assert property (
    @(posedge clk) disable iff (!rst_n)
    (pipe_valid && (inflight_q != '0)) |-> $past(issue_valid, PIPE_LATENCY)
  );

endmodule

// File: tb/tb_stitch_pipeline_egress_buffer.sv
module tb_stitch_pipeline_egress_buffer;

  logic        clk;
  logic        rst_n;
  logic        issue_ready;
  logic        issue_valid;
  logic        pipe_valid;
  logic [31:0] pipe_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  occupancy;
  logic [2:0]  inflight;
  logic        err_overflow;
  logic        err_underflow;
  logic        err_protocol;

  logic [31:0] issue_data;
  logic        force_pv;
  logic [31:0] force_pd;
  logic [2:0]  pv;
  logic [31:0] pd [3];
  logic [2:0]  errs;

  int n_checks;
  int n_fail;

  stitch_pipeline_egress_buffer #(
    .DATA_WIDTH   (32),
    .DEPTH        (4),
    .PIPE_LATENCY (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_ready   (issue_ready),
    .issue_valid   (issue_valid),
    .pipe_valid    (pipe_valid),
    .pipe_data     (pipe_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .occupancy     (occupancy),
    .inflight      (inflight),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_protocol  (err_protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three-stage valid-only pipeline sharing the reset domain; adds 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv <= '0;
    else        pv <= {pv[1:0], issue_valid};
  end
  always_ff @(posedge clk) begin
    pd[0] <= issue_data + 32'd3;
    pd[1] <= pd[0];
    pd[2] <= pd[1];
  end
  assign pipe_valid = pv[2] | force_pv;
  assign pipe_data  = force_pv ? force_pd : pd[2];
  assign errs       = {err_overflow, err_underflow, err_protocol};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_n(input int n);
    for (int k = 0; k < n; k++) begin
      issue_valid = 1'b1;
      cyc();
      issue_data++;
    end
    issue_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int unsigned exp_val;
    int n_iss;
    int n_rx;

    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_data  = '0;
    out_ready   = 1'b0;
    force_pv    = 1'b0;
    force_pd    = '0;

    // 1: reset state
    #2;
    check_eq("rst_issue_ready", 32'(issue_ready), 1);
    check_eq("rst_occupancy", 32'(occupancy), 0);
    check_eq("rst_inflight", 32'(inflight), 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_errs", 32'(errs), 0);
    #10 rst_n = 1'b1;
    cyc();

    // 2: streaming; 4 credits each held 5 edges -> 4 issues per 5 cycles
    out_ready = 1'b1;
    exp_val   = 3;
    n_iss     = 0;
    n_rx      = 0;
    for (int i = 0; i < 40; i++) begin
      issue_valid = (i < 24) ? issue_ready : 1'b0;
      if (out_valid) begin
        check_eq("t2_data", out_data, exp_val);
        exp_val++;
        n_rx++;
      end
      cyc();
      if (issue_valid) begin
        issue_data++;
        n_iss++;
      end
    end
    issue_valid = 1'b0;
    check_eq("t2_issued", 32'(n_iss), 20);
    check_eq("t2_received", 32'(n_rx), 20);
    check_eq("t2_errs", 32'(errs), 0);
    check_eq("t2_occupancy", 32'(occupancy), 0);
    check_eq("t2_inflight", 32'(inflight), 0);

    // 3: fill with out_ready low, then drain
    out_ready = 1'b0;
    base = issue_data;
    issue_n(4);
    check_eq("t3_ready_low", 32'(issue_ready), 0);
    check_eq("t3_inflight", 32'(inflight), 3);
    check_eq("t3_occ_early", 32'(occupancy), 1);
    cyc(); cyc(); cyc();
    check_eq("t3_occ_full", 32'(occupancy), 4);
    check_eq("t3_inflight0", 32'(inflight), 0);
    check_eq("t3_out_valid", 32'(out_valid), 1);
    check_eq("t3_ready_full", 32'(issue_ready), 0);
    check_eq("t3_head", out_data, base + 3);
    out_ready = 1'b1;
    cyc();
    check_eq("t3_ready_back", 32'(issue_ready), 1);
    check_eq("t3_occ_after_pop", 32'(occupancy), 3);
    for (int k = 1; k < 4; k++) begin
      check_eq("t3_drain", out_data, base + 3 + k);
      cyc();
    end
    check_eq("t3_empty", 32'(out_valid), 0);
    out_ready = 1'b0;

    // 4: full FIFO with push and pop on the same edge
    base = issue_data;
    issue_n(4);
    cyc(); cyc(); cyc();
    check_eq("t4_occ_full", 32'(occupancy), 4);
    issue_n(1);
    check_eq("t4_protocol", 32'(err_protocol), 1);
    check_eq("t4_inflight", 32'(inflight), 1);
    cyc(); cyc();
    out_ready = 1'b1;
    cyc();
    check_eq("t4_occ_stays", 32'(occupancy), 4);
    check_eq("t4_no_overflow", 32'(err_overflow), 0);
    check_eq("t4_inflight0", 32'(inflight), 0);
    for (int k = 1; k <= 4; k++) begin
      check_eq("t4_order", out_data, base + 3 + k);
      cyc();
    end
    check_eq("t4_empty", 32'(out_valid), 0);

    // 5a: return with nothing in flight
    force_pv = 1'b1;
    force_pd = 32'hDEAD_BEEF;
    cyc();
    force_pv = 1'b0;
    check_eq("t5_underflow", 32'(err_underflow), 1);
    check_eq("t5_inflight_sat", 32'(inflight), 0);
    check_eq("t5_occ_push", 32'(occupancy), 1);
    check_eq("t5_forced_data", out_data, 32'hDEAD_BEEF);
    cyc();
    check_eq("t5_occ_drained", 32'(occupancy), 0);

    // 5b: overflow drops the beat
    out_ready = 1'b0;
    base = issue_data;
    issue_n(4);
    cyc(); cyc(); cyc();
    check_eq("t5_occ_full", 32'(occupancy), 4);
    check_eq("t5_no_overflow_yet", 32'(err_overflow), 0);
    issue_n(1);
    cyc(); cyc(); cyc();
    check_eq("t5_overflow", 32'(err_overflow), 1);
    check_eq("t5_occ_still", 32'(occupancy), 4);
    check_eq("t5_inflight0", 32'(inflight), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("t5_drain", out_data, base + 3 + k);
      cyc();
    end
    check_eq("t5_dropped", 32'(out_valid), 0);
    check_eq("t5_errs_sticky", 32'(errs), 7);
    out_ready = 1'b0;

    // 6: asynchronous reset with 2 in FIFO and 2 in flight
    issue_n(4);
    cyc();
    check_eq("t6_occ_pre", 32'(occupancy), 2);
    check_eq("t6_inflight_pre", 32'(inflight), 2);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_occ", 32'(occupancy), 0);
    check_eq("t6_rst_inflight", 32'(inflight), 0);
    check_eq("t6_rst_out_valid", 32'(out_valid), 0);
    check_eq("t6_rst_ready", 32'(issue_ready), 1);
    check_eq("t6_rst_errs", 32'(errs), 0);
    #2 rst_n = 1'b1;
    cyc();
    base = issue_data;
    issue_n(1);
    check_eq("t6_inflight1", 32'(inflight), 1);
    cyc(); cyc();
    check_eq("t6_no_stale", 32'(occupancy), 0);
    cyc();
    check_eq("t6_occ1", 32'(occupancy), 1);
    check_eq("t6_data", out_data, base + 3);
    check_eq("t6_inflight0", 32'(inflight), 0);
    check_eq("t6_errs", 32'(errs), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
